muldiv_seq: RTL and testbench

- Iterative unsigned multiply/divide sequencer for the RV32 core's M-extension subset (MUL, DIVU, REMU).
- Holds no adder or subtractor of its own. It borrows the shared 32-bit ALU by driving that ALU's op1/op2/alu_op each cycle and capturing its result.
- Sits beside the execute stage. A mux in front of the ALU selects the sequencer's operands while alu_own is high.

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_muldiv_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response and shared-ALU borrowing signals of the multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_func;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            alu_own;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_result;

  modport slave (
    input  req_valid, req_func, req_a, req_b, kill, resp_ready, alu_result,
    output req_ready, resp_valid, resp_data, alu_own, alu_op1, alu_op2, alu_op
  );

  modport master (
    output req_valid, req_func, req_a, req_b, kill, resp_ready, alu_result,
    input  req_ready, resp_valid, resp_data, alu_own, alu_op1, alu_op2, alu_op
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIVU/REMU sequencer that borrows the shared ALU for 32 cycles.
// ALU drive outputs are registered from next-state values so the ALU sees them the cycle they apply.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZDIV, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_DIVU, OP_REMU} op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // hi: accumulator / remainder, lo: multiplicand / quotient, bb: multiplier / divisor
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, bb_q, bb_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            alu_own_q, alu_own_d;
  logic [XLEN-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MUL;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      bb_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      alu_own_q    <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      bb_q         <= bb_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      alu_own_q    <= alu_own_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_op_q     <= alu_op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    bb_d        = bb_q;
    resp_data_d = resp_data_q;
    r_shift     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = bus.req_a;
          bb_d  = bus.req_b;
          case (bus.req_func)
            2'b01:   op_d = OP_DIVU;
            2'b10:   op_d = OP_REMU;
            default: op_d = OP_MUL;
          endcase
          state_d = (op_d != OP_MUL && bus.req_b == '0) ? S_ZDIV : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q == OP_MUL) begin
            hi_d = bus.alu_result;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
            bb_d = {1'b0, bb_q[XLEN-1:1]};
          end else if (r_shift >= bb_q) begin
            hi_d = bus.alu_result;
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = r_shift;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d     = S_DONE;
            resp_data_d = (op_q == OP_DIVU) ? lo_d : hi_d;
          end
        end
      end
      S_ZDIV: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_DONE;
          resp_data_d = (op_q == OP_DIVU) ? '1 : lo_q;
        end
      end
      S_DONE: begin
        if (bus.kill || bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    alu_own_d    = (state_d == S_RUN);
    alu_op1_d    = '0;
    alu_op2_d    = '0;
    alu_op_d     = '0;
    if (state_d == S_RUN) begin
      if (op_d == OP_MUL) begin
        alu_op_d  = ALU_ADD;
        alu_op1_d = hi_d;
        alu_op2_d = bb_d[0] ? lo_d : '0;
      end else begin
        alu_op_d  = ALU_SUB;
        alu_op1_d = {hi_d[XLEN-2:0], lo_d[XLEN-1]};
        alu_op2_d = bb_d;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.alu_own    = alu_own_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.alu_op     = alu_op_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural shared ALU beside it.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat, own;

  always #5 clk = ~clk;

  muldiv_seq_if bus ();
  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Shared execute-stage ALU
  always_comb begin
    case (bus.alu_op)
      4'b0010: bus.alu_result = bus.alu_op1 + bus.alu_op2;
      4'b0110: bus.alu_result = bus.alu_op1 - bus.alu_op2;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [3:0] exp_op,
                           output int l, output int o);
    l = 1;
    o = 0;
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'(exp_op));
    while (!bus.resp_valid && l < 100) begin
      if (bus.alu_own) o++;
      tick();
      l++;
    end
  endtask

  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] exp_op, input logic [31:0] exp_data,
                       input int exp_lat, input int exp_own, input string tag);
    int l, o;
    start(f, a, b, tag);
    wait_resp(tag, exp_op, l, o);
    chk({tag, "_latency"}, 32'(l), 32'(exp_lat));
    chk({tag, "_alu_own_cycles"}, 32'(o), 32'(exp_own));
    chk({tag, "_data"}, bus.resp_data, exp_data);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, "_resp_valid_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_data"},  bus.resp_data,       32'd0);
    chk({tag, "_alu_own"},    32'(bus.alu_own),    32'd0);
    chk({tag, "_alu_op1"},    bus.alu_op1,         32'd0);
    chk({tag, "_alu_op2"},    bus.alu_op2,         32'd0);
    chk({tag, "_alu_op"},     32'(bus.alu_op),     32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_func   = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    do_op(2'b00, 32'd7, 32'd6, 4'b0010, 32'd42, 33, 32, "mul_7x6");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 32'h0000_0001, 33, 32, "mul_ones");
    do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 4'b0010, 32'h0000_0000, 33, 32, "mul_ovf");
    do_op(2'b11, 32'd5, 32'd3, 4'b0010, 32'd15, 33, 32, "mul_rsvd");
    do_op(2'b01, 32'd100, 32'd7, 4'b0110, 32'd14, 33, 32, "divu_100_7");
    do_op(2'b10, 32'd100, 32'd7, 4'b0110, 32'd2, 33, 32, "remu_100_7");
    do_op(2'b01, 32'd5, 32'd9, 4'b0110, 32'd0, 33, 32, "divu_5_9");
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 4'b0110, 32'd0, 33, 32, "remu_ones_1");
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0110, 32'd1, 33, 32, "divu_big");
    do_op(2'b01, 32'd123, 32'd0, 4'b0000, 32'hFFFF_FFFF, 2, 0, "divu_zero");
    do_op(2'b10, 32'd123, 32'd0, 4'b0000, 32'd123, 2, 0, "remu_zero");

    // Response held off while a second request is offered
    start(2'b00, 32'd3, 32'd5, "hold");
    wait_resp("hold", 4'b0010, lat, own);
    chk("hold_latency", 32'(lat), 32'd33);
    bus.req_valid = 1'b1;
    bus.req_func  = 2'b00;
    bus.req_a     = 32'd2;
    bus.req_b     = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", bus.resp_data, 32'd15);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("hold_release_valid", 32'(bus.resp_valid), 32'd0);
    chk("hold_release_ready", 32'(bus.req_ready), 32'd1);
    chk("hold_not_accepted", 32'(bus.alu_own), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    wait_resp("hold_next", 4'b0010, lat, own);
    chk("hold_next_latency", 32'(lat), 32'd33);
    chk("hold_next_data", bus.resp_data, 32'd4);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // Kill at iteration 10
    start(2'b00, 32'd9, 32'd9, "kill");
    repeat (10) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("kill_req_ready", 32'(bus.req_ready), 32'd1);
    chk("kill_alu_own", 32'(bus.alu_own), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) chk("kill_no_resp", 32'(bus.resp_valid), 32'd0);
      tick();
    end
    chk("kill_idle_ready", 32'(bus.req_ready), 32'd1);
    do_op(2'b00, 32'd3, 32'd4, 4'b0010, 32'd12, 33, 32, "kill_next_mul");

    // Kill in IDLE blocks acceptance
    bus.kill = 1'b1;
    bus.req_valid = 1'b1;
    tick();
    bus.kill = 1'b0;
    bus.req_valid = 1'b0;
    chk("kill_idle_block", 32'(bus.alu_own), 32'd0);

    // Reset at iteration 10
    start(2'b01, 32'd1000, 32'd3, "rst");
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_mid");
    rst_n = 1'b1;
    tick();
    do_op(2'b01, 32'd1000, 32'd3, 4'b0110, 32'd333, 33, 32, "rst_next_div");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
